// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard controller bus.
// It carries the ID/EX/WB stage tags into the controller and the per-stage
// enables, flushes and forwarding selects back out to the pipeline registers.
interface pipe_hazard_ctrl_if #(
  parameter int REG_W = 6,
  parameter int CNT_W = 32
);
  // Stage tags presented by the pipeline
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic             ex_valid;
  logic [REG_W-1:0] ex_rd;
  logic             ex_we;
  logic             ex_is_load;
  logic             ex_multicycle;
  logic             branch_taken;
  logic             wb_valid;
  logic [REG_W-1:0] wb_rd;
  logic             wb_we;

  // Controls returned to the pipeline
  logic             if_en;
  logic             id_en;
  logic             ex_en;
  logic             id_flush;
  logic             ex_flush;
  logic             wb_flush;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             mc_done;
  logic [CNT_W-1:0] stall_cycles;

  // Pipeline side: drives stage tags, consumes controls
  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           ex_valid, ex_rd, ex_we, ex_is_load, ex_multicycle, branch_taken,
           wb_valid, wb_rd, wb_we,
    input  if_en, id_en, ex_en, id_flush, ex_flush, wb_flush,
           fwd_a_sel, fwd_b_sel, mc_done, stall_cycles
  );

  // Controller side: consumes stage tags, drives controls
  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           ex_valid, ex_rd, ex_we, ex_is_load, ex_multicycle, branch_taken,
           wb_valid, wb_rd, wb_we,
    output if_en, id_en, ex_en, id_flush, ex_flush, wb_flush,
           fwd_a_sel, fwd_b_sel, mc_done, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard / sequencing controller for a three-register RISC-V pipeline.
// Produces stage enables and flushes for load-use stalls, multi-cycle EX
// operations and taken branches, ID operand forwarding selects, and a
// saturating count of fetch-stall cycles. Everything except the stall counter
// is combinational from the state and the stage tags.
module pipe_hazard_ctrl #(
  parameter int REG_W  = 6,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 32
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int MC_W = $clog2(MC_LAT + 1);
  // Reload value so that the op occupies EX for exactly MC_LAT cycles:
  // one cycle in RUN, then MC_LAT-1 cycles in MC_BUSY counting down to 0.
  localparam logic [MC_W-1:0] MC_LOAD = (MC_LAT > 1) ? MC_W'(MC_LAT - 2) : '0;

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    RUN      = 2'd1,
    MC_BUSY  = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [MC_W-1:0]  mc_cnt;
  logic [MC_W-1:0]  mc_cnt_nxt;
  logic [CNT_W-1:0] stall_cycles;

  logic       exm_1, exm_2, wbm_1, wbm_2, load_use;
  logic [1:0] fwd_a_c, fwd_b_c;
  logic       if_en_c, id_en_c, ex_en_c;
  logic       id_flush_c, ex_flush_c, wb_flush_c;
  logic [1:0] fwd_a_out, fwd_b_out;
  logic       mc_done_c;

  // Register matches against EX and WB producers; register 0 never matches
  always_comb begin
    exm_1 = bus.ex_valid & bus.ex_we & (bus.ex_rd != '0) & bus.id_rs1_used & (bus.ex_rd == bus.id_rs1);
    exm_2 = bus.ex_valid & bus.ex_we & (bus.ex_rd != '0) & bus.id_rs2_used & (bus.ex_rd == bus.id_rs2);
    wbm_1 = bus.wb_valid & bus.wb_we & (bus.wb_rd != '0) & bus.id_rs1_used & (bus.wb_rd == bus.id_rs1);
    wbm_2 = bus.wb_valid & bus.wb_we & (bus.wb_rd != '0) & bus.id_rs2_used & (bus.wb_rd == bus.id_rs2);
    load_use = bus.ex_is_load & (exm_1 | exm_2);
  end

  // Forwarding priority: a non-load EX result beats WB; load data is not ready in EX
  always_comb begin
    fwd_a_c = 2'b00;
    fwd_b_c = 2'b00;
    if (exm_1 && !bus.ex_is_load) begin
      fwd_a_c = 2'b10;
    end else if (wbm_1) begin
      fwd_a_c = 2'b01;
    end else begin
      fwd_a_c = 2'b00;
    end
    if (exm_2 && !bus.ex_is_load) begin
      fwd_b_c = 2'b10;
    end else if (wbm_2) begin
      fwd_b_c = 2'b01;
    end else begin
      fwd_b_c = 2'b00;
    end
  end

  // Next-state and stage-control decode; priority multicycle > branch > load-use
  always_comb begin
    next_state = state;
    mc_cnt_nxt = mc_cnt;
    if_en_c    = 1'b0;
    id_en_c    = 1'b0;
    ex_en_c    = 1'b0;
    id_flush_c = 1'b0;
    ex_flush_c = 1'b0;
    wb_flush_c = 1'b0;
    fwd_a_out  = 2'b00;
    fwd_b_out  = 2'b00;
    mc_done_c  = 1'b0;
    case (state)
      RST_HOLD: begin
        id_flush_c = 1'b1;
        ex_flush_c = 1'b1;
        wb_flush_c = 1'b1;
        next_state = RUN;
      end
      RUN: begin
        if_en_c   = 1'b1;
        id_en_c   = 1'b1;
        ex_en_c   = 1'b1;
        fwd_a_out = fwd_a_c;
        fwd_b_out = fwd_b_c;
        if (bus.ex_valid && bus.ex_multicycle) begin
          if (MC_LAT > 1) begin
            // Freeze the whole front end and keep bubbles flowing into WB
            if_en_c    = 1'b0;
            id_en_c    = 1'b0;
            ex_en_c    = 1'b0;
            wb_flush_c = 1'b1;
            mc_cnt_nxt = MC_LOAD;
            next_state = MC_BUSY;
          end else begin
            // Single-cycle latency: result is ready now
            mc_done_c = 1'b1;
          end
        end else if (bus.branch_taken && bus.ex_valid) begin
          // Kill the two younger instructions in IF/ID and ID/EX
          id_flush_c = 1'b1;
          ex_flush_c = 1'b1;
        end else if (load_use) begin
          // Hold IF and ID one cycle, insert a bubble behind the load
          if_en_c    = 1'b0;
          id_en_c    = 1'b0;
          ex_flush_c = 1'b1;
        end else begin
          next_state = RUN;
        end
      end
      MC_BUSY: begin
        fwd_a_out = fwd_a_c;
        fwd_b_out = fwd_b_c;
        if (mc_cnt == '0) begin
          // Last EX cycle: result advances and the pipeline resumes
          if_en_c    = 1'b1;
          id_en_c    = 1'b1;
          ex_en_c    = 1'b1;
          mc_done_c  = 1'b1;
          next_state = RUN;
        end else begin
          wb_flush_c = 1'b1;
          mc_cnt_nxt = mc_cnt - MC_W'(1);
        end
      end
      default: begin
        id_flush_c = 1'b1;
        ex_flush_c = 1'b1;
        wb_flush_c = 1'b1;
        next_state = RST_HOLD;
      end
    endcase
  end

  // State and multi-cycle countdown registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RST_HOLD;
      mc_cnt <= '0;
    end else begin
      state  <= next_state;
      mc_cnt <= mc_cnt_nxt;
    end
  end

  // Saturating count of cycles with fetch held, excluding the reset hold cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if ((state != RST_HOLD) && !if_en_c && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end else begin
      stall_cycles <= stall_cycles;
    end
  end

  assign bus.if_en        = if_en_c;
  assign bus.id_en        = id_en_c;
  assign bus.ex_en        = ex_en_c;
  assign bus.id_flush     = id_flush_c;
  assign bus.ex_flush     = ex_flush_c;
  assign bus.wb_flush     = wb_flush_c;
  assign bus.fwd_a_sel    = fwd_a_out;
  assign bus.fwd_b_sel    = fwd_b_out;
  assign bus.mc_done      = mc_done_c;
  assign bus.stall_cycles = stall_cycles;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a table of RUN-state vectors with
// hand-computed controls, plus sequences for reset, load-use, branch and
// multi-cycle behaviour.
module tb_pipe_hazard_ctrl;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   exp_stall;

  pipe_hazard_ctrl_if #(.REG_W(6), .CNT_W(32)) bus ();

  pipe_hazard_ctrl #(.REG_W(6), .MC_LAT(4), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [5:0] rs1;
    logic [5:0] rs2;
    logic       u1;
    logic       u2;
    logic       exv;
    logic [5:0] exrd;
    logic       exwe;
    logic       exld;
    logic       exmc;
    logic       br;
    logic       wbv;
    logic [5:0] wbrd;
    logic       wbwe;
    logic [5:0] ctl;   // {if_en,id_en,ex_en,id_flush,ex_flush,wb_flush}
    logic [1:0] fa;
    logic [1:0] fb;
    logic       done;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.id_rs1        = v.rs1;
    bus.id_rs2        = v.rs2;
    bus.id_rs1_used   = v.u1;
    bus.id_rs2_used   = v.u2;
    bus.ex_valid      = v.exv;
    bus.ex_rd         = v.exrd;
    bus.ex_we         = v.exwe;
    bus.ex_is_load    = v.exld;
    bus.ex_multicycle = v.exmc;
    bus.branch_taken  = v.br;
    bus.wb_valid      = v.wbv;
    bus.wb_rd         = v.wbrd;
    bus.wb_we         = v.wbwe;
  endtask

  task automatic idle();
    vec_t z;
    z = '{6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0,
          6'b000000, 2'b00, 2'b00, 1'b0};
    drive(z);
  endtask

  function automatic logic [5:0] ctl_now();
    return {bus.if_en, bus.id_en, bus.ex_en, bus.id_flush, bus.ex_flush, bus.wb_flush};
  endfunction

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    exp_stall = 0;

    //            rs1    rs2    u1    u2    exv   exrd   exwe  exld  exmc  br    wbv   wbrd   wbwe  ctl         fa     fb     done
    vecs[0]  = '{6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'b111000, 2'b00, 2'b00, 1'b0};
    vecs[1]  = '{6'd0, 6'd5, 1'b0, 1'b1, 1'b1, 6'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'b001010, 2'b00, 2'b00, 1'b0};
    vecs[2]  = '{6'd0, 6'd0, 1'b1, 1'b0, 1'b1, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'b111000, 2'b00, 2'b00, 1'b0};
    vecs[3]  = '{6'd5, 6'd0, 1'b0, 1'b0, 1'b1, 6'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'b111000, 2'b00, 2'b00, 1'b0};
    vecs[4]  = '{6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 6'b111110, 2'b00, 2'b00, 1'b0};
    vecs[5]  = '{6'd5, 6'd0, 1'b1, 1'b0, 1'b1, 6'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 6'b111110, 2'b00, 2'b00, 1'b0};
    vecs[6]  = '{6'd7, 6'd0, 1'b1, 1'b0, 1'b1, 6'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd7, 1'b1, 6'b111000, 2'b10, 2'b00, 1'b0};
    vecs[7]  = '{6'd7, 6'd0, 1'b1, 1'b0, 1'b1, 6'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd7, 1'b1, 6'b111000, 2'b01, 2'b00, 1'b0};
    vecs[8]  = '{6'd0, 6'd9, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd9, 1'b1, 6'b111000, 2'b00, 2'b01, 1'b0};
    vecs[9]  = '{6'd0, 6'd0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 1'b1, 6'b111000, 2'b00, 2'b00, 1'b0};
    vecs[10] = '{6'd4, 6'd0, 1'b1, 1'b0, 1'b0, 6'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 6'b111000, 2'b00, 2'b00, 1'b0};
    vecs[11] = '{6'd3, 6'd3, 1'b1, 1'b1, 1'b1, 6'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'b111000, 2'b10, 2'b10, 1'b0};
    vecs[12] = '{6'd2, 6'd0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd2, 1'b1, 6'b111000, 2'b00, 2'b00, 1'b0};
    vecs[13] = '{6'd6, 6'd0, 1'b1, 1'b0, 1'b1, 6'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd6, 1'b1, 6'b001010, 2'b01, 2'b00, 1'b0};

    // Reset: hold outputs while asserted and for the first cycle after release
    rst_n = 1'b0;
    idle();
    #2;
    chk("rst_ctl", 64'(ctl_now()), 64'(6'b000111));
    chk("rst_fwd", 64'({bus.fwd_a_sel, bus.fwd_b_sel, bus.mc_done}), 64'(5'b00000));
    chk("rst_stall", 64'(bus.stall_cycles), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("hold_ctl", 64'(ctl_now()), 64'(6'b000111));
    @(negedge clk);
    #2;
    chk("run_ctl", 64'(ctl_now()), 64'(6'b111000));
    chk("run_stall", 64'(bus.stall_cycles), 64'd0);

    // Table of single-cycle RUN vectors
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #2;
      chk($sformatf("vec%0d", i),
          64'({ctl_now(), bus.fwd_a_sel, bus.fwd_b_sel, bus.mc_done}),
          64'({vecs[i].ctl, vecs[i].fa, vecs[i].fb, vecs[i].done}));
      if (!vecs[i].ctl[5]) exp_stall++;
    end
    @(negedge clk);
    idle();
    #2;
    chk("table_stall", 64'(bus.stall_cycles), 64'(exp_stall));

    // Load-use on rs2, then the load reaches WB and forwards from there
    @(negedge clk);
    idle();
    bus.id_rs2 = 6'd5; bus.id_rs2_used = 1'b1;
    bus.ex_valid = 1'b1; bus.ex_rd = 6'd5; bus.ex_we = 1'b1; bus.ex_is_load = 1'b1;
    #2;
    chk("lu_ctl", 64'(ctl_now()), 64'(6'b001010));
    exp_stall++;
    @(negedge clk);
    idle();
    bus.id_rs2 = 6'd5; bus.id_rs2_used = 1'b1;
    bus.wb_valid = 1'b1; bus.wb_rd = 6'd5; bus.wb_we = 1'b1;
    #2;
    chk("lu_next_ctl", 64'(ctl_now()), 64'(6'b111000));
    chk("lu_next_fwdb", 64'(bus.fwd_b_sel), 64'(2'b01));
    chk("lu_stall", 64'(bus.stall_cycles), 64'(exp_stall));

    // Branch coinciding with load-use: branch wins, no stall afterwards
    @(negedge clk);
    idle();
    bus.id_rs1 = 6'd5; bus.id_rs1_used = 1'b1;
    bus.ex_valid = 1'b1; bus.ex_rd = 6'd5; bus.ex_we = 1'b1; bus.ex_is_load = 1'b1;
    bus.branch_taken = 1'b1;
    #2;
    chk("br_lu_ctl", 64'(ctl_now()), 64'(6'b111110));
    @(negedge clk);
    idle();
    bus.id_rs1 = 6'd5; bus.id_rs1_used = 1'b1;
    #2;
    chk("br_after_ctl", 64'(ctl_now()), 64'(6'b111000));
    chk("br_stall", 64'(bus.stall_cycles), 64'(exp_stall));

    // Multi-cycle op (MC_LAT=4) with a branch that must be ignored
    @(negedge clk);
    idle();
    bus.ex_valid = 1'b1; bus.ex_rd = 6'd8; bus.ex_we = 1'b1;
    bus.ex_multicycle = 1'b1; bus.branch_taken = 1'b1;
    #2;
    chk("mc0_ctl", 64'({ctl_now(), bus.mc_done}), 64'(7'b0000010));
    exp_stall++;
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      bus.id_rs1 = 6'd8; bus.id_rs1_used = 1'b1;
      #2;
      chk($sformatf("mc%0d_ctl", k), 64'({ctl_now(), bus.mc_done}), 64'(7'b0000010));
      chk($sformatf("mc%0d_fwda", k), 64'(bus.fwd_a_sel), 64'(2'b10));
      exp_stall++;
    end
    @(negedge clk);
    #2;
    chk("mc3_ctl", 64'({ctl_now(), bus.mc_done}), 64'(7'b1110001));
    chk("mc_stall", 64'(bus.stall_cycles), 64'(exp_stall));
    @(negedge clk);
    idle();
    #2;
    chk("mc_after", 64'({ctl_now(), bus.mc_done}), 64'(7'b1110000));

    // Asynchronous reset in the middle of MC_BUSY
    @(negedge clk);
    bus.ex_valid = 1'b1; bus.ex_multicycle = 1'b1; bus.ex_rd = 6'd3; bus.ex_we = 1'b1;
    @(negedge clk);
    #2;
    chk("mcb_ctl", 64'(ctl_now()), 64'(6'b000001));
    #1;
    rst_n = 1'b0;
    #1;
    exp_stall = 0;
    chk("arst_ctl", 64'({ctl_now(), bus.mc_done}), 64'(7'b0001110));
    chk("arst_stall", 64'(bus.stall_cycles), 64'(exp_stall));
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    #2;
    chk("arst_hold", 64'(ctl_now()), 64'(6'b000111));
    @(negedge clk);
    #2;
    chk("arst_run", 64'(ctl_now()), 64'(6'b111000));
    chk("arst_run_stall", 64'(bus.stall_cycles), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
